// File: rtl/ram_repl_nr2w.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ram_repl_nr2w
//
// Multi-ported RAM with NUM_RD registered read ports and two write ports.
// Each write port owns a group of NUM_RD replicated banks, one bank per read
// port. A 1-bit live-value table (LVT) records which write port last wrote
// each address, and each read port uses it to pick between its two banks.
//
// After reset the block runs an initialisation pass that writes zero to
// every address of every bank and to the LVT. It does this one address per
// cycle. While this pass runs, external writes are ignored and r_dout is
// held at zero. When the pass is done, ready goes high.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous reset, active low
//   w_addr_1     write port 1 address
//   w_din_1      write port 1 data
//   w_enb_1      write port 1 enable (active high)
//   w_addr_2     write port 2 address
//   w_din_2      write port 2 data
//   w_enb_2      write port 2 enable (active high)
//   r_addr       packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   r_dout       packed registered read data, port k at [k*DATA_W +: DATA_W]
//   ready        high once the initialisation pass has completed
//   wr_conflict  one-cycle pulse after a same-address dual write
// ---------------------------------------------------------------------------
module ram_repl_nr2w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11,
  parameter int NUM_RD = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          w_addr_1,
  input  logic [DATA_W-1:0]          w_din_1,
  input  logic                       w_enb_1,
  input  logic [ADDR_W-1:0]          w_addr_2,
  input  logic [DATA_W-1:0]          w_din_2,
  input  logic                       w_enb_2,
  input  logic [NUM_RD*ADDR_W-1:0]   r_addr,
  output logic [NUM_RD*DATA_W-1:0]   r_dout,
  output logic                       ready,
  output logic                       wr_conflict
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  clr_cnt;

  // Initialisation pass active: banks and LVT take the clear write.
  logic clr_en;

  // Qualified write strobes. Port 2 is dropped entirely when both ports
  // hit the same address, so port 1 wins in both the banks and the LVT.
  logic same_addr;
  logic we_1;
  logic we_2;
  logic conflict;

  always_comb begin
    clr_en    = (state == S_INIT);
    same_addr = (w_addr_1 == w_addr_2);
    conflict  = (state == S_READY) && w_enb_1 && w_enb_2 && same_addr;
    we_1      = (state == S_READY) && w_enb_1;
    we_2      = (state == S_READY) && w_enb_2 && !conflict;
  end

  // -------------------------------------------------------------------------
  // Control FSM: clear-address counter plus the registered status outputs.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // block sees the pre-edge value of every register regardless of order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_INIT;
      clr_cnt     <= '0;
      ready       <= 1'b0;
      wr_conflict <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          wr_conflict <= 1'b0;
          clr_cnt     <= clr_cnt + 1'b1;
          // The last address is being cleared on this edge.
          if (&clr_cnt) begin
            state <= S_READY;
            ready <= 1'b1;
          end
        end
        S_READY: begin
          ready       <= 1'b1;
          wr_conflict <= conflict;
        end
        default: begin
          state       <= S_INIT;
          clr_cnt     <= '0;
          ready       <= 1'b0;
          wr_conflict <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Live-value table: 0 means write port 1 was last, 1 means write port 2.
  // -------------------------------------------------------------------------
  logic lvt [DEPTH];

  // NOTE: memories have no reset branch. The initialisation pass clears
  // them instead, so they can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      lvt[clr_cnt] <= 1'b0;
    end else begin
      if (we_1) lvt[w_addr_1] <= 1'b0;
      if (we_2) lvt[w_addr_2] <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Per-read-port replicated banks and output registers.
  // bank_1 belongs to write port 1 and bank_2 to write port 2. Each read port
  // has its own copy of both, so every bank needs only one read port.
  // -------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    logic [DATA_W-1:0] bank_1 [DEPTH];
    logic [DATA_W-1:0] bank_2 [DEPTH];
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_q;

    assign rd_addr = r_addr[k*ADDR_W +: ADDR_W];

    always_ff @(posedge clk) begin
      if (clr_en) begin
        bank_1[clr_cnt] <= '0;
        bank_2[clr_cnt] <= '0;
      end else begin
        if (we_1) bank_1[w_addr_1] <= w_din_1;
        if (we_2) bank_2[w_addr_2] <= w_din_2;
      end
    end

    // The banks and the LVT are read with pre-edge contents. A read that
    // coincides with a write to the same address therefore returns the old
    // data.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_q <= '0;
      end else if (state == S_INIT) begin
        rd_q <= '0;
      end else begin
        rd_q <= lvt[rd_addr] ? bank_2[rd_addr] : bank_1[rd_addr];
      end
    end

    assign r_dout[k*DATA_W +: DATA_W] = rd_q;
  end

endmodule

// File: tb/tb_ram_repl_nr2w.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_ram_repl_nr2w
//
// Directed bench for ram_repl_nr2w with DATA_W=32, ADDR_W=4 (16 words) and
// NUM_RD=8. Inputs change 1 ns after a rising edge, and outputs are sampled
// at the same point.
// ---------------------------------------------------------------------------
module tb_ram_repl_nr2w;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NUM_RD = 8;
  localparam int DEPTH  = 16;

  logic                      clk;
  logic                      rst;
  logic [ADDR_W-1:0]         w_addr_1;
  logic [DATA_W-1:0]         w_din_1;
  logic                      w_enb_1;
  logic [ADDR_W-1:0]         w_addr_2;
  logic [DATA_W-1:0]         w_din_2;
  logic                      w_enb_2;
  logic [NUM_RD*ADDR_W-1:0]  r_addr;
  logic [NUM_RD*DATA_W-1:0]  r_dout;
  logic                      ready;
  logic                      wr_conflict;

  int vectors;
  int miscompares;

  ram_repl_nr2w #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .w_addr_1    (w_addr_1),
    .w_din_1     (w_din_1),
    .w_enb_1     (w_enb_1),
    .w_addr_2    (w_addr_2),
    .w_din_2     (w_din_2),
    .w_enb_2     (w_enb_2),
    .r_addr      (r_addr),
    .r_dout      (r_dout),
    .ready       (ready),
    .wr_conflict (wr_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all_raddr(input logic [ADDR_W-1:0] a);
    for (int k = 0; k < NUM_RD; k++) r_addr[k*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic idle_writes();
    w_enb_1  = 1'b0;
    w_enb_2  = 1'b0;
    w_addr_1 = '0;
    w_addr_2 = '0;
    w_din_1  = '0;
    w_din_2  = '0;
  endtask

  // Reset, then the initialisation pass with writes held active.
  task automatic test_reset();
    logic [DATA_W-1:0] got;
    idle_writes();
    set_all_raddr(4'd3);
    rst = 1'b0;
    #2;
    vectors++;
    if (ready !== 1'b0 || wr_conflict !== 1'b0) begin
      $display("FAIL reset_status: ready=%b wr_conflict=%b, want 0/0", ready, wr_conflict);
      miscompares++;
    end
    vectors++;
    if (r_dout !== '0) begin
      $display("FAIL reset_dout: r_dout=%h, want 0", r_dout);
      miscompares++;
    end
    step();
    step();
    // Both ports write the same address throughout INIT. These writes must be
    // ignored and must raise no conflict.
    w_enb_1  = 1'b1;
    w_enb_2  = 1'b1;
    w_din_1  = 32'hFFFF_FFFF;
    w_din_2  = 32'h5555_5555;
    rst      = 1'b1;
    for (int c = 1; c <= DEPTH; c++) begin
      w_addr_1 = 4'(c - 1);
      w_addr_2 = 4'(c - 1);
      step();
      vectors++;
      if (ready !== (c == DEPTH)) begin
        $display("FAIL init_ready cycle %0d: ready=%b, want %b", c, ready, (c == DEPTH));
        miscompares++;
      end
      vectors++;
      if (wr_conflict !== 1'b0) begin
        $display("FAIL init_conflict cycle %0d: wr_conflict=%b, want 0", c, wr_conflict);
        miscompares++;
      end
    end
    idle_writes();
    // Port k reads address (a+k)%16, so all addresses are covered on all ports.
    for (int a = 0; a < DEPTH; a++) begin
      for (int k = 0; k < NUM_RD; k++) r_addr[k*ADDR_W +: ADDR_W] = 4'((a + k) % DEPTH);
      step();
      for (int k = 0; k < NUM_RD; k++) begin
        got = r_dout[k*DATA_W +: DATA_W];
        vectors++;
        if (got !== '0) begin
          $display("FAIL init_clear port %0d addr %0d: got %h, want 0", k, (a + k) % DEPTH, got);
          miscompares++;
        end
      end
    end
  endtask

  // Port 1 write, then all ports read the address on the next cycle.
  task automatic test_write_read();
    logic [DATA_W-1:0] got;
    w_addr_1 = 4'd3;
    w_din_1  = 32'hDEAD_BEEF;
    w_enb_1  = 1'b1;
    step();
    idle_writes();
    set_all_raddr(4'd3);
    step();
    for (int k = 0; k < NUM_RD; k++) begin
      got = r_dout[k*DATA_W +: DATA_W];
      vectors++;
      if (got !== 32'hDEAD_BEEF) begin
        $display("FAIL write_read port %0d: got %h, want deadbeef", k, got);
        miscompares++;
      end
    end
  endtask

  // Port 2 overwrites the port 1 value, so the LVT must select group 2.
  task automatic test_lvt();
    logic [DATA_W-1:0] got;
    w_addr_1 = 4'd5;
    w_din_1  = 32'h1111_1111;
    w_enb_1  = 1'b1;
    step();
    idle_writes();
    w_addr_2 = 4'd5;
    w_din_2  = 32'h2222_2222;
    w_enb_2  = 1'b1;
    step();
    idle_writes();
    set_all_raddr(4'd5);
    step();
    for (int k = 0; k < NUM_RD; k++) begin
      got = r_dout[k*DATA_W +: DATA_W];
      vectors++;
      if (got !== 32'h2222_2222) begin
        $display("FAIL lvt_select port %0d: got %h, want 22222222", k, got);
        miscompares++;
      end
    end
  endtask

  // Same-address dual write: port 1 wins and the conflict pulse lasts one
  // cycle. A different-address dual write completes both writes.
  task automatic test_conflict();
    logic [DATA_W-1:0] got;
    logic [DATA_W-1:0] exp;
    w_addr_1 = 4'd7;
    w_din_1  = 32'hAAAA_0000;
    w_enb_1  = 1'b1;
    w_addr_2 = 4'd7;
    w_din_2  = 32'hBBBB_0000;
    w_enb_2  = 1'b1;
    step();
    vectors++;
    if (wr_conflict !== 1'b1) begin
      $display("FAIL conflict_pulse: wr_conflict=%b, want 1", wr_conflict);
      miscompares++;
    end
    idle_writes();
    set_all_raddr(4'd7);
    step();
    vectors++;
    if (wr_conflict !== 1'b0) begin
      $display("FAIL conflict_clear: wr_conflict=%b, want 0", wr_conflict);
      miscompares++;
    end
    for (int k = 0; k < NUM_RD; k++) begin
      got = r_dout[k*DATA_W +: DATA_W];
      vectors++;
      if (got !== 32'hAAAA_0000) begin
        $display("FAIL conflict_winner port %0d: got %h, want aaaa0000", k, got);
        miscompares++;
      end
    end
    w_addr_1 = 4'd10;
    w_din_1  = 32'hCAFE_0001;
    w_enb_1  = 1'b1;
    w_addr_2 = 4'd11;
    w_din_2  = 32'hCAFE_0002;
    w_enb_2  = 1'b1;
    step();
    vectors++;
    if (wr_conflict !== 1'b0) begin
      $display("FAIL dual_no_conflict: wr_conflict=%b, want 0", wr_conflict);
      miscompares++;
    end
    idle_writes();
    for (int k = 0; k < NUM_RD; k++) r_addr[k*ADDR_W +: ADDR_W] = (k % 2 == 0) ? 4'd10 : 4'd11;
    step();
    for (int k = 0; k < NUM_RD; k++) begin
      got = r_dout[k*DATA_W +: DATA_W];
      exp = (k % 2 == 0) ? 32'hCAFE_0001 : 32'hCAFE_0002;
      vectors++;
      if (got !== exp) begin
        $display("FAIL dual_write port %0d: got %h, want %h", k, got, exp);
        miscompares++;
      end
    end
  endtask

  // A read in the same cycle as a write to the same address returns old data.
  task automatic test_read_during_write();
    logic [DATA_W-1:0] got;
    set_all_raddr(4'd9);
    w_addr_1 = 4'd9;
    w_din_1  = 32'h1234_5678;
    w_enb_1  = 1'b1;
    step();
    idle_writes();
    for (int k = 0; k < NUM_RD; k++) begin
      got = r_dout[k*DATA_W +: DATA_W];
      vectors++;
      if (got !== '0) begin
        $display("FAIL rdw_old port %0d: got %h, want 0", k, got);
        miscompares++;
      end
    end
    step();
    got = r_dout[0 +: DATA_W];
    vectors++;
    if (got !== 32'h1234_5678) begin
      $display("FAIL rdw_new port 0: got %h, want 12345678", got);
      miscompares++;
    end
  endtask

  // Reset during INIT restarts the clear pass from address 0.
  task automatic test_reset_mid_init();
    logic [DATA_W-1:0] got;
    idle_writes();
    set_all_raddr(4'd3);
    rst = 1'b0;
    #1;
    vectors++;
    if (ready !== 1'b0 || r_dout !== '0) begin
      $display("FAIL async_reset: ready=%b r_dout=%h, want 0/0", ready, r_dout);
      miscompares++;
    end
    step();
    rst = 1'b1;
    for (int c = 0; c < 8; c++) step();
    rst = 1'b0;
    #1;
    vectors++;
    if (ready !== 1'b0) begin
      $display("FAIL midinit_reset: ready=%b, want 0", ready);
      miscompares++;
    end
    step();
    rst = 1'b1;
    for (int c = 1; c <= DEPTH; c++) begin
      step();
      vectors++;
      if (ready !== (c == DEPTH)) begin
        $display("FAIL reinit_ready cycle %0d: ready=%b, want %b", c, ready, (c == DEPTH));
        miscompares++;
      end
    end
    step();
    for (int k = 0; k < NUM_RD; k++) begin
      got = r_dout[k*DATA_W +: DATA_W];
      vectors++;
      if (got !== '0) begin
        $display("FAIL reinit_clear port %0d: got %h, want 0", k, got);
        miscompares++;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    r_addr      = '0;
    idle_writes();
    test_reset();
    test_write_read();
    test_lvt();
    test_conflict();
    test_read_during_write();
    test_reset_mid_init();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_repl_nr2w.md
RAM_REPL_NR2W -- requirements
Module: ram_repl_nr2w

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 11, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter NUM_RD, default 8, number of read ports (1..16).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 w_addr_1  input  ADDR_W  write port 1 address.
REQ-007 w_din_1  input  DATA_W  write port 1 data.
REQ-008 w_enb_1  input  1  write port 1 enable, active-high.
REQ-009 w_addr_2  input  ADDR_W  write port 2 address.
REQ-010 w_din_2  input  DATA_W  write port 2 data.
REQ-011 w_enb_2  input  1  write port 2 enable, active-high.
REQ-012 r_addr  input  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-013 r_dout  output  NUM_RD*DATA_W  packed registered read data; port k at bits [k*DATA_W +: DATA_W].
REQ-014 ready  output  1  high once initialisation clear completes.
REQ-015 wr_conflict  output  1  one-cycle pulse on same-address dual write.

Function
REQ-016 Storage SHALL be 2*NUM_RD replicated banks (one per write port per read port) plus a live-value table (LVT), DEPTH entries of 1 bit, recording which write port last wrote each address.
REQ-017 Write port p SHALL write all NUM_RD banks of group p and set LVT[addr]=p-1 in the same cycle.
REQ-018 Read latency SHALL be exactly 1 cycle: r_dout for port k at edge N+1 reflects r_addr sampled at edge N, bank selected by LVT value read at edge N.
REQ-019 Read-during-write to the same address SHALL return the old (pre-write) data; new data visible from the following read.
REQ-020 Both enables high with equal addresses: port 1 SHALL win, port 2 write dropped entirely (banks and LVT), wr_conflict=1 for that one cycle; otherwise wr_conflict=0.
REQ-021 Both enables high with different addresses: both writes SHALL complete in the same cycle.
REQ-022 FSM states: INIT, READY. Reset enters INIT with clear counter 0.
REQ-023 INIT SHALL write 0 to address counter in all banks and LVT=0 each cycle, counter incrementing by 1; after writing DEPTH-1 the FSM SHALL enter READY (DEPTH cycles total), counter wrap not exercised.
REQ-024 In INIT: ready=0, external writes ignored, wr_conflict held 0, r_dout driven 0.
REQ-025 In READY: ready=1, remains READY until reset; no other transition.
REQ-026 Addresses SHALL be used unmodified as ADDR_W bits; no out-of-range case exists.

Reset
REQ-027 On rst low, asynchronously: FSM=INIT, counter=0, ready=0, wr_conflict=0, all r_dout=0; bank contents undefined until clear completes.
REQ-028 rst asserted mid-INIT or mid-write SHALL restart the clear from address 0 on deassertion.
REQ-029 First clear write SHALL occur on the first rising edge after rst deasserts.

Verification (ADDR_W=4, DEPTH=16, NUM_RD=8, DATA_W=32)
REQ-030 Release reset, hold w_enb_1=1 -> ready rises after 16 cycles; all 8 ports read 0 at every address; ignored writes leave data 0.
REQ-031 Port1 writes 0xDEADBEEF @3, next cycle all ports read @3 -> every r_dout = 0xDEADBEEF one cycle after address applied.
REQ-032 Port1 writes 0x11111111 @5, then port2 writes 0x22222222 @5 -> all ports read 0x22222222 (LVT selects group 2).
REQ-033 Same cycle port1 0xAAAA0000 @7, port2 0xBBBB0000 @7 -> wr_conflict=1 one cycle; reads @7 return 0xAAAA0000.
REQ-034 Port1 writes 0x12345678 @9 while port 0 reads @9 -> old value 0 returned; next-cycle read returns 0x12345678.
REQ-035 Assert rst at INIT cycle 8, release -> ready low, rises 16 cycles after release; @3 reads 0.
